cute_key_sequencer: RTL and testbench

- Controller that stores a per-phase key schedule and drives the key inputs and phase counter of a counter-gated, key-muxed locked core. The core uses one key per counter state.
- Sits between the key-provisioning interface and the locked core's keyinput/phase pins.
- Owns the phase counter, so key and phase are always coherent.
- Gates the core with core_en until a complete schedule is loaded and a run is requested.

---
 rtl/cute_key_sequencer_if.sv | 14 +
 rtl/cute_key_sequencer.sv | 126 ++++++++++++
 tb/tb_cute_key_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cute_key_sequencer_if.sv
// Key-provisioning handshake for cute_key_sequencer: one config word per accepted beat.
interface cute_key_sequencer_if #(
    parameter int unsigned KEY_W = 2,
    parameter int unsigned PH_W  = 1
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PH_W-1:0]  cfg_slot;
    logic [KEY_W-1:0] cfg_key;
    logic             cfg_last;

    modport master (output cfg_valid, cfg_slot, cfg_key, cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, cfg_slot, cfg_key, cfg_last, output cfg_ready);
endinterface

// File: rtl/cute_key_sequencer.sv
// Per-phase key schedule controller for a counter-gated, key-muxed locked core.
// Optional KEYSEQ_ZEROIZE_EN adds a zeroize input that also wipes key storage.
module cute_key_sequencer #(
    parameter int unsigned KEY_W     = 2,
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned PH_W      = 1
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef KEYSEQ_ZEROIZE_EN
    input  logic                  zeroize,
`endif
    cute_key_sequencer_if.slave   cfg,
    input  logic                  run_start,
    input  logic                  run_stop,
    output logic [KEY_W-1:0]      key_out,
    output logic [PH_W-1:0]       phase,
    output logic                  core_en,
    output logic                  busy,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, LOAD, ARMED, RUN} state_t;

    state_t                state, state_nx;
    logic [NUM_SLOTS-1:0]  loaded, loaded_nx;
    logic [KEY_W-1:0]      slots [NUM_SLOTS];
    logic                  err_nx;
    logic                  wr_en;
    logic                  accept;
    logic                  slot_ok;
    logic                  clr;
    logic [PH_W-1:0]       phase_inc, phase_nx;
    logic [KEY_W-1:0]      key_nx;

    always_comb begin
`ifdef KEYSEQ_ZEROIZE_EN
        clr = reset | zeroize;
`else
        clr = reset;
`endif
    end

    always_comb begin
        accept    = cfg.cfg_valid & cfg.cfg_ready;
        slot_ok   = 32'(cfg.cfg_slot) < NUM_SLOTS;
        phase_inc = (32'(phase) == NUM_SLOTS - 1) ? '0 : phase + 1'b1;
        state_nx  = state;
        loaded_nx = loaded;
        err_nx    = err;
        wr_en     = 1'b0;
        phase_nx  = '0;
        key_nx    = '0;

        case (state)
            IDLE, LOAD: begin
                if (accept) begin
                    if (state == IDLE) begin
                        err_nx    = 1'b0;
                        loaded_nx = '0;
                    end
                    state_nx = LOAD;
                    if (!slot_ok) begin
                        err_nx    = 1'b1;
                        state_nx  = IDLE;
                        loaded_nx = '0;
                    end else begin
                        wr_en                   = 1'b1;
                        loaded_nx[cfg.cfg_slot] = 1'b1;
                        if (cfg.cfg_last) begin
                            if (&loaded_nx) begin
                                state_nx = ARMED;
                            end else begin
                                err_nx    = 1'b1;
                                state_nx  = IDLE;
                                loaded_nx = '0;
                            end
                        end
                    end
                end
            end
            ARMED:   if (run_start && !run_stop) state_nx = RUN;
            RUN:     if (run_stop) state_nx = ARMED;
            default: state_nx = IDLE;
        endcase

        // Slot 0 may be written on the same edge that arms, so forward it.
        if (state_nx == RUN && state == RUN) begin
            phase_nx = phase_inc;
            key_nx   = slots[phase_inc];
        end else if (state_nx == ARMED || state_nx == RUN) begin
            key_nx = (wr_en && cfg.cfg_slot == '0) ? cfg.cfg_key : slots[0];
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state         <= IDLE;
            loaded        <= '0;
            err           <= 1'b0;
            phase         <= '0;
            key_out       <= '0;
            core_en       <= 1'b0;
            busy          <= 1'b0;
            cfg.cfg_ready <= 1'b0;
        end else begin
            state         <= state_nx;
            loaded        <= loaded_nx;
            err           <= err_nx;
            phase         <= phase_nx;
            key_out       <= key_nx;
            core_en       <= (state_nx == RUN);
            busy          <= (state_nx == RUN);
            cfg.cfg_ready <= (state_nx == IDLE) || (state_nx == LOAD);
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
`ifdef KEYSEQ_ZEROIZE_EN
            for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
`endif
        end else if (wr_en) begin
            slots[cfg.cfg_slot] <= cfg.cfg_key;
        end
    end
endmodule

// File: tb/tb_cute_key_sequencer.sv
// Self-checking bench for cute_key_sequencer (3 slots to exercise non-power-of-two wrap and out-of-range slots).
module tb_cute_key_sequencer;
    localparam int NS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_start = 1'b0;
    logic run_stop = 1'b0;
    logic zero_in = 1'b0;
    logic [1:0] key_out;
    logic [1:0] phase;
    logic core_en, busy, err;

    int checks = 0;
    int errors = 0;

    cute_key_sequencer_if #(.KEY_W(2), .PH_W(2)) cfg_bus ();

    cute_key_sequencer #(.KEY_W(2), .NUM_SLOTS(NS), .PH_W(2)) dut (
        .clock     (clk),
        .reset     (rst),
`ifdef KEYSEQ_ZEROIZE_EN
        .zeroize   (zero_in),
`endif
        .cfg       (cfg_bus),
        .run_start (run_start),
        .run_stop  (run_stop),
        .key_out   (key_out),
        .phase     (phase),
        .core_en   (core_en),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural model: schedule contents plus a few flags describing what the controller is doing.
    int  m_key [NS];
    bit  [NS-1:0] m_loaded;
    bit  m_valid = 0, m_ready = 0, m_sched = 0, m_run = 0, m_fresh = 1, m_err = 0;
    int  m_phase = 0, m_keyout = 0;

    initial for (int i = 0; i < NS; i++) m_key[i] = 0;

    always @(posedge clk) begin
        int s;
        s = int'(cfg_bus.cfg_slot);
        m_valid = 1;
        if (rst || zero_in) begin
            if (zero_in) for (int i = 0; i < NS; i++) m_key[i] = 0;
            m_ready = 0; m_sched = 0; m_run = 0; m_fresh = 1; m_err = 0;
            m_phase = 0; m_keyout = 0; m_loaded = '0;
        end else if (!m_sched) begin
            if (cfg_bus.cfg_valid && m_ready) begin
                if (m_fresh) begin m_err = 0; m_loaded = '0; end
                m_fresh = 0;
                if (s >= NS) begin
                    m_err = 1; m_fresh = 1; m_loaded = '0;
                end else begin
                    m_key[s] = int'(cfg_bus.cfg_key);
                    m_loaded[s] = 1'b1;
                    if (cfg_bus.cfg_last) begin
                        if (m_loaded == {NS{1'b1}}) m_sched = 1;
                        else begin m_err = 1; m_fresh = 1; m_loaded = '0; end
                    end
                end
            end
            m_phase = 0;
            m_keyout = m_sched ? m_key[0] : 0;
            m_ready = !m_sched;
        end else if (!m_run) begin
            if (run_start && !run_stop) m_run = 1;
            m_phase = 0; m_keyout = m_key[0];
        end else if (run_stop) begin
            m_run = 0; m_phase = 0; m_keyout = m_key[0];
        end else begin
            m_phase = (m_phase + 1) % NS;
            m_keyout = m_key[m_phase];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_key_out", int'(key_out), m_keyout);
            check("cmp_phase", int'(phase), m_phase);
            check("cmp_core_en", int'(core_en), int'(m_run));
            check("cmp_busy", int'(busy), int'(m_run));
            check("cmp_err", int'(err), int'(m_err));
            check("cmp_cfg_ready", int'(cfg_bus.cfg_ready), int'(m_ready));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int slot, input int key, input bit last);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_slot = 2'(slot);
        cfg_bus.cfg_key = 2'(key);
        cfg_bus.cfg_last = last;
        tick(1);
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_last = 1'b0;
    endtask

    task automatic pulse_start();
        run_start = 1'b1; tick(1); run_start = 1'b0;
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_slot = '0;
        cfg_bus.cfg_key = '0;
        cfg_bus.cfg_last = 1'b0;
        tick(2);
        check("rst_ready", int'(cfg_bus.cfg_ready), 0);
        check("rst_core_en", int'(core_en), 0);
        check("rst_key", int'(key_out), 0);
        rst = 1'b0;
        tick(1);
        check("idle_ready", int'(cfg_bus.cfg_ready), 1);

        // Full load and run with wrap 0,1,2,0,1
        send(0, 2, 0); send(1, 1, 0); send(2, 3, 1);
        check("armed_key", int'(key_out), 2);
        check("armed_ready", int'(cfg_bus.cfg_ready), 0);
        check("armed_core_en", int'(core_en), 0);
        pulse_start();
        check("run0_phase", int'(phase), 0);
        check("run0_key", int'(key_out), 2);
        check("run0_core_en", int'(core_en), 1);
        tick(1); check("run1_key", int'(key_out), 1);
        tick(1); check("run2_key", int'(key_out), 3);
        tick(1); check("wrap_phase", int'(phase), 0);
        check("wrap_key", int'(key_out), 2);
        tick(1); check("run_p1", int'(phase), 1);
        run_stop = 1'b1; tick(1); run_stop = 1'b0;
        check("stop_phase", int'(phase), 0);
        check("stop_key", int'(key_out), 2);
        check("stop_core_en", int'(core_en), 0);
        run_start = 1'b1; run_stop = 1'b1; tick(1);
        run_start = 1'b0; run_stop = 1'b0;
        check("start_stop_core_en", int'(core_en), 0);

        // Reset mid-run at phase 1
        pulse_start(); tick(1);
        check("pre_rst_phase", int'(phase), 1);
        rst = 1'b1; tick(1);
        check("midrst_key", int'(key_out), 0);
        check("midrst_core_en", int'(core_en), 0);
        rst = 1'b0; tick(1);
        send(2, 3, 1);
        check("partial_err", int'(err), 1);
        check("partial_ready", int'(cfg_bus.cfg_ready), 1);
        pulse_start();
        check("partial_no_run", int'(core_en), 0);

        // Out-of-range slot, then a clean reload
        send(0, 1, 0);
        check("first_word_clr_err", int'(err), 0);
        send(3, 0, 0);
        check("oob_err", int'(err), 1);
        send(0, 2, 0);
        check("reload_err_clr", int'(err), 0);
        send(1, 1, 0); send(1, 0, 0); send(2, 3, 1);
        check("reload_armed_ready", int'(cfg_bus.cfg_ready), 0);
        pulse_start(); tick(1);
        check("rewrite_key", int'(key_out), 0);

        // cfg_last with only slot 0 loaded
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        send(0, 1, 1);
        check("short_err", int'(err), 1);
        pulse_start();
        check("short_no_run", int'(core_en), 0);

`ifdef KEYSEQ_ZEROIZE_EN
        send(0, 1, 0); send(1, 2, 0); send(2, 3, 1);
        pulse_start(); tick(1);
        zero_in = 1'b1; tick(1); zero_in = 1'b0;
        check("zero_key", int'(key_out), 0);
        check("zero_core_en", int'(core_en), 0);
        tick(1);
        send(1, 2, 1);
        check("zero_partial_err", int'(err), 1);
        send(0, 3, 0); send(1, 2, 0); send(2, 1, 1);
        check("zero_reload_key", int'(key_out), 3);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 2000; n++) begin
            cfg_bus.cfg_valid = ($urandom_range(0, 1) == 1);
            cfg_bus.cfg_slot = 2'($urandom_range(0, 3));
            cfg_bus.cfg_key = 2'($urandom_range(0, 3));
            cfg_bus.cfg_last = ($urandom_range(0, 3) == 0);
            run_start = ($urandom_range(0, 3) == 0);
            run_stop = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 59) == 0);
`ifdef KEYSEQ_ZEROIZE_EN
            zero_in = ($urandom_range(0, 79) == 0);
`endif
            tick(1);
        end
        rst = 1'b0; zero_in = 1'b0;
        cfg_bus.cfg_valid = 1'b0; run_start = 1'b0; run_stop = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
